// File: rtl/mcu_pkg.sv
// Shared definitions for the mcu_mc accumulator core:
// opcodes, FSM state encoding and status-word flag positions.
package mcu_pkg;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_JLT = 4'h7;
  localparam logic [3:0] OP_JNE = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  function automatic int N_BIT(int dw);
    return dw - 1;
  endfunction

  function automatic int Z_BIT(int dw);
    return dw - 2;
  endfunction

endpackage

// File: rtl/mcu_mc_if.sv
// Memory bus between the core (master) and program/data memory (slave).
// req/we/addr/wdata from master; rdata/ready from slave.
interface mcu_mc_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mcu_alu.sv
// Combinational ALU: op selects result from a (accumulator) and b (memory).
// Ports: op, a, b in; result, n (a<b), z (a==b) out.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DW         = 16,
  parameter int CMP_SIGNED = 0
)(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z
);

  always_comb begin
    result = a;
    case (op)
      OP_LD:   result = b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = a;
    endcase
    if (CMP_SIGNED != 0)
      n = $signed(a) < $signed(b);
    else
      n = a < b;
    z = (a == b);
  end

endmodule

// File: rtl/mcu_mc.sv
// Multi-cycle accumulator core: FETCH/DECODE/EXEC/HALT over a req/ready bus.
// Ports: clock, reset (async high), mem (bus master), halted, dbg_pc/a/sw.
module mcu_mc
  import mcu_pkg::*;
#(
  parameter int            DW         = 16,
  parameter int            AW         = 12,
  parameter int            CMP_SIGNED = 0,
  parameter logic [AW-1:0] RESET_PC   = '0
)(
  input  logic          clock,
  input  logic          reset,
  mcu_mc_if.master      mem,
  output logic          halted,
  output logic [AW-1:0] dbg_pc,
  output logic [DW-1:0] dbg_a,
  output logic [DW-1:0] dbg_sw
);

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] c, c_n;
  logic [AW-1:0] addr, addr_n;
  logic [3:0]    op, op_n;
  logic [DW-1:0] a, a_n;
  logic [DW-1:0] wdata, wdata_n;
  logic [DW-1:0] alu_res;
  logic          n_f, n_n, z_f, z_n;
  logic          req, req_n, we, we_n;
  logic          hlt, hlt_n;
  logic          alu_n, alu_z;
  logic          take, is_mem;

  mcu_alu #(
    .DW(DW),
    .CMP_SIGNED(CMP_SIGNED)
  ) u_alu (
    .op(op),
    .a(a),
    .b(mem.rdata),
    .result(alu_res),
    .n(alu_n),
    .z(alu_z)
  );

  // IR is kept as its two live fields; bits between them are don't-care.
  always_comb begin
    take   = 1'b0;
    is_mem = 1'b0;
    case (op)
      OP_JMP: take = 1'b1;
      OP_JEQ: take = z_f;
      OP_JNE: take = !z_f;
      OP_JLT: take = n_f;
      OP_LD, OP_ADD, OP_ST, OP_CMP,
      OP_SUB, OP_AND, OP_OR: is_mem = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    c_n     = c;
    op_n    = op;
    a_n     = a;
    n_n     = n_f;
    z_n     = z_f;
    req_n   = req;
    we_n    = we;
    addr_n  = addr;
    wdata_n = wdata;
    hlt_n   = hlt;
    case (state)
      FETCH: begin
        // First cycle after reset has no request out yet.
        if (!req) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc;
        end else if (mem.ready) begin
          op_n    = mem.rdata[DW-1 -: 4];
          c_n     = mem.rdata[AW-1:0];
          pc_n    = pc + STEP;
          req_n   = 1'b0;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (op == OP_HLT) begin
          state_n = HALT;
          hlt_n   = 1'b1;
        end else if (is_mem) begin
          state_n = EXEC;
          req_n   = 1'b1;
          we_n    = (op == OP_ST);
          addr_n  = c;
          wdata_n = a;
        end else begin
          state_n = FETCH;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = take ? c : pc;
          if (take) pc_n = c;
        end
      end
      EXEC: begin
        if (mem.ready) begin
          case (op)
            OP_ST: ;
            OP_CMP: begin
              n_n = alu_n;
              z_n = alu_z;
            end
            default: a_n = alu_res;
          endcase
          // Next fetch is issued on the same edge.
          state_n = FETCH;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = pc;
        end
      end
      HALT: begin
        req_n = 1'b0;
        hlt_n = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      c     <= '0;
      op    <= '0;
      a     <= '0;
      n_f   <= 1'b0;
      z_f   <= 1'b0;
      req   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      hlt   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      c     <= c_n;
      op    <= op_n;
      a     <= a_n;
      n_f   <= n_n;
      z_f   <= z_n;
      req   <= req_n;
      we    <= we_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      hlt   <= hlt_n;
    end
  end

  assign mem.req   = req;
  assign mem.we    = we;
  assign mem.addr  = addr;
  assign mem.wdata = wdata;
  assign halted    = hlt;
  assign dbg_pc    = pc;
  assign dbg_a     = a;

  always_comb begin
    dbg_sw = '0;
    dbg_sw[N_BIT(DW)] = n_f;
    dbg_sw[Z_BIT(DW)] = z_f;
  end

endmodule

// File: tb/tb_mcu_mc.sv
// Directed bench for mcu_mc: three cores (16b unsigned, 16b signed, 32b)
// on word-array memories; writes checked against an expected-write queue.
module tb_mcu_mc;
  import mcu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic rdy0 = 1'b1;
  int   rmode = 0;
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  bit   chk_stab = 1'b0;

  logic [15:0] mem0 [0:2047];
  logic [31:0] mem2 [0:16383];
  logic [27:0] exp_q [$];
  logic [15:0] f2_q [$];

  logic        h0, h1, h2;
  logic [11:0] pc0, pc1;
  logic [15:0] pc2;
  logic [15:0] a0, a1, sw0, sw1;
  logic [31:0] a2, sw2;

  mcu_mc_if #(.DW(16), .AW(12)) m0 ();
  mcu_mc_if #(.DW(16), .AW(12)) m1 ();
  mcu_mc_if #(.DW(32), .AW(16)) m2 ();

  assign m0.rdata = mem0[m0.addr[11:1]];
  assign m0.ready = rdy0;
  assign m1.rdata = mem0[m1.addr[11:1]];
  assign m1.ready = 1'b1;
  assign m2.rdata = mem2[m2.addr[15:2]];
  assign m2.ready = 1'b1;

  mcu_mc #(.DW(16), .AW(12), .CMP_SIGNED(0), .RESET_PC(12'h000)) dut0 (
    .clock(clock), .reset(rst0), .mem(m0), .halted(h0),
    .dbg_pc(pc0), .dbg_a(a0), .dbg_sw(sw0));

  mcu_mc #(.DW(16), .AW(12), .CMP_SIGNED(1), .RESET_PC(12'h000)) dut1 (
    .clock(clock), .reset(rst1), .mem(m1), .halted(h1),
    .dbg_pc(pc1), .dbg_a(a1), .dbg_sw(sw1));

  mcu_mc #(.DW(32), .AW(16), .CMP_SIGNED(0), .RESET_PC(16'hFFFC)) dut2 (
    .clock(clock), .reset(rst2), .mem(m2), .halted(h2),
    .dbg_pc(pc2), .dbg_a(a2), .dbg_sw(sw2));

  // Ready pattern generator for dut0.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      cnt++;
      case (rmode)
        1:       rdy0 = (cnt % 3 == 0);
        2:       rdy0 = ~m0.we;
        default: rdy0 = 1'b1;
      endcase
    end
  end

  // Memory writes, write scoreboard, request stability and fetch log.
  logic        pend = 1'b0;
  logic [11:0] la = '0;
  logic        lw = 1'b0;
  always @(posedge clock) begin
    logic [27:0] e;
    if (m0.req === 1'b1 && m0.we === 1'b1 && m0.ready === 1'b1) begin
      mem0[m0.addr[11:1]] <= m0.wdata;
      wr_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL wr0_unexpected observed=%h expected=none", {m0.addr, m0.wdata});
      end else begin
        e = exp_q.pop_front();
        assert ({m0.addr, m0.wdata} === e) else begin
          fails++;
          $error("FAIL wr0 observed=%h expected=%h", {m0.addr, m0.wdata}, e);
        end
      end
    end
    if (chk_stab && pend) begin
      tests++;
      assert (m0.req === 1'b1 && m0.addr === la && m0.we === lw) else begin
        fails++;
        $error("FAIL stall_stable observed=%b/%h/%b expected=1/%h/%b",
               m0.req, m0.addr, m0.we, la, lw);
      end
    end
    pend = (m0.req === 1'b1) && (m0.ready !== 1'b1);
    la = m0.addr;
    lw = m0.we;
    if (m1.req === 1'b1 && m1.we === 1'b1) begin
      tests++;
      fails++;
      $error("FAIL wr1_unexpected observed=%h expected=none", m1.addr);
    end
    if (m2.req === 1'b1 && m2.ready === 1'b1) begin
      if (m2.we === 1'b1) begin
        tests++;
        fails++;
        $error("FAIL wr2_unexpected observed=%h expected=none", m2.addr);
      end else begin
        f2_q.push_back(m2.addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] i16(input logic [3:0] o, input logic [11:0] c);
    return {o, c};
  endfunction

  task automatic ld0(input logic [11:0] ad, input logic [15:0] d);
    mem0[ad[11:1]] <= d;
  endtask

  task automatic hold0();
    @(negedge clock);
    rst0 = 1'b1;
  endtask

  task automatic go0();
    @(negedge clock);
    rst0 = 1'b0;
  endtask

  task automatic wait_halt0(input int budget, output int k, output int first);
    k = 0;
    first = -1;
    while (k < budget && h0 !== 1'b1) begin
      @(negedge clock);
      k++;
      if (first < 0 && m0.req === 1'b1) first = k;
    end
    chk("halt0_reached", {31'd0, h0}, 32'd1);
  endtask

  task automatic wait_halt(input int which, input int budget);
    int k;
    logic h;
    k = 0;
    h = (which == 1) ? h1 : h2;
    while (k < budget && h !== 1'b1) begin
      @(negedge clock);
      k++;
      h = (which == 1) ? h1 : h2;
    end
    chk($sformatf("halt%0d_reached", which), {31'd0, h}, 32'd1);
  endtask

  task automatic load_basic();
    ld0(12'h000, i16(OP_LD,  12'h020));
    ld0(12'h002, i16(OP_ADD, 12'h022));
    ld0(12'h004, i16(OP_ST,  12'h024));
    ld0(12'h006, i16(OP_HLT, 12'h000));
    ld0(12'h020, 16'h0003);
    ld0(12'h022, 16'h0004);
    ld0(12'h024, 16'h0000);
  endtask

  initial begin
    int k, first;
    for (int i = 0; i < 2048; i++) mem0[i] <= '0;
    for (int i = 0; i < 16384; i++) mem2[i] <= '0;

    // Reset state.
    @(negedge clock);
    chk("rst_req",   {31'd0, m0.req},  32'd0);
    chk("rst_we",    {31'd0, m0.we},   32'd0);
    chk("rst_addr",  {20'd0, m0.addr}, 32'd0);
    chk("rst_wdata", {16'd0, m0.wdata}, 32'd0);
    chk("rst_halt",  {31'd0, h0},      32'd0);
    chk("rst_pc",    {20'd0, pc0},     32'd0);
    chk("rst_a",     {16'd0, a0},      32'd0);
    chk("rst_sw",    {16'd0, sw0},     32'd0);
    chk("rst_pc32",  {16'd0, pc2},     32'h0000FFFC);

    // Basic program, zero wait states.
    load_basic();
    exp_q.push_back({12'h024, 16'h0007});
    go0();
    wait_halt0(200, k, first);
    chk("basic_cycles", k - first, 32'd11);
    chk("basic_mem",    {16'd0, mem0[12'h024 >> 1]}, 32'h7);
    chk("basic_pc",     {20'd0, pc0}, 32'h8);
    chk("basic_a",      {16'd0, a0},  32'h7);
    chk("basic_sw",     {16'd0, sw0}, 32'h0);
    chk("basic_q",      exp_q.size(), 32'd0);

    // Same program, ready every third cycle.
    hold0();
    load_basic();
    exp_q.push_back({12'h024, 16'h0007});
    rmode = 1;
    chk_stab = 1'b1;
    go0();
    wait_halt0(400, k, first);
    chk_stab = 1'b0;
    rmode = 0;
    chk("stall_mem", {16'd0, mem0[12'h024 >> 1]}, 32'h7);
    chk("stall_pc",  {20'd0, pc0}, 32'h8);
    chk("stall_a",   {16'd0, a0},  32'h7);
    chk("stall_q",   exp_q.size(), 32'd0);

    // Unsigned CMP FFFF vs 1: N=0 Z=0; JEQ/JLT not taken, JNE taken.
    hold0();
    ld0(12'h000, i16(OP_LD,  12'h040));
    ld0(12'h002, i16(OP_CMP, 12'h042));
    ld0(12'h004, i16(OP_JEQ, 12'h010));
    ld0(12'h006, i16(OP_JLT, 12'h010));
    ld0(12'h008, i16(OP_JNE, 12'h00C));
    ld0(12'h00A, i16(OP_HLT, 12'h000));
    ld0(12'h00C, i16(OP_LD,  12'h044));
    ld0(12'h00E, i16(OP_HLT, 12'h000));
    ld0(12'h010, i16(OP_HLT, 12'h000));
    ld0(12'h040, 16'hFFFF);
    ld0(12'h042, 16'h0001);
    ld0(12'h044, 16'h0055);
    go0();
    wait_halt0(200, k, first);
    chk("cmpu_sw", {16'd0, sw0}, 32'h0);
    chk("cmpu_a",  {16'd0, a0},  32'h55);
    chk("cmpu_pc", {20'd0, pc0}, 32'h10);

    // Equal compare: Z=1; JNE/JLT not taken, JEQ taken.
    hold0();
    ld0(12'h002, i16(OP_CMP, 12'h040));
    ld0(12'h004, i16(OP_JNE, 12'h010));
    ld0(12'h008, i16(OP_JEQ, 12'h00C));
    go0();
    wait_halt0(200, k, first);
    chk("cmpz_sw", {16'd0, sw0}, 32'h4000);
    chk("cmpz_a",  {16'd0, a0},  32'h55);
    chk("cmpz_pc", {20'd0, pc0}, 32'h10);

    // JLT program: unsigned core falls through, signed core jumps.
    hold0();
    ld0(12'h002, i16(OP_CMP, 12'h042));
    ld0(12'h004, i16(OP_JLT, 12'h00C));
    ld0(12'h006, i16(OP_HLT, 12'h000));
    go0();
    wait_halt0(200, k, first);
    chk("jltu_sw", {16'd0, sw0}, 32'h0);
    chk("jltu_a",  {16'd0, a0},  32'hFFFF);
    chk("jltu_pc", {20'd0, pc0}, 32'h8);
    @(negedge clock);
    rst1 = 1'b0;
    wait_halt(1, 200);
    chk("jlts_sw", {16'd0, sw1}, 32'h8000);
    chk("jlts_a",  {16'd0, a1},  32'h55);
    chk("jlts_pc", {20'd0, pc1}, 32'h10);
    rst1 = 1'b1;

    // Countdown loop: SUB/ST/CMP/JNE, five stores 4..0.
    hold0();
    ld0(12'h000, i16(OP_LD,  12'h040));
    ld0(12'h002, i16(OP_SUB, 12'h042));
    ld0(12'h004, i16(OP_ST,  12'h046));
    ld0(12'h006, i16(OP_CMP, 12'h044));
    ld0(12'h008, i16(OP_JNE, 12'h002));
    ld0(12'h00A, i16(OP_HLT, 12'h000));
    ld0(12'h040, 16'h0005);
    ld0(12'h042, 16'h0001);
    ld0(12'h044, 16'h0000);
    ld0(12'h046, 16'hBEEF);
    for (int v = 4; v >= 0; v--) exp_q.push_back({12'h046, 16'(v)});
    wr_cnt = 0;
    go0();
    wait_halt0(400, k, first);
    chk("loop_writes", wr_cnt, 32'd5);
    chk("loop_a",   {16'd0, a0},  32'h0);
    chk("loop_sw",  {16'd0, sw0}, 32'h4000);
    chk("loop_pc",  {20'd0, pc0}, 32'hC);
    chk("loop_mem", {16'd0, mem0[12'h046 >> 1]}, 32'h0);
    chk("loop_q",   exp_q.size(), 32'd0);

    // AND / OR then store.
    hold0();
    ld0(12'h000, i16(OP_LD,  12'h050));
    ld0(12'h002, i16(OP_AND, 12'h052));
    ld0(12'h004, i16(OP_OR,  12'h054));
    ld0(12'h006, i16(OP_ST,  12'h056));
    ld0(12'h008, i16(OP_HLT, 12'h000));
    ld0(12'h050, 16'h0FF0);
    ld0(12'h052, 16'h3C3C);
    ld0(12'h054, 16'h8001);
    exp_q.push_back({12'h056, 16'h8C31});
    go0();
    wait_halt0(200, k, first);
    chk("logic_a",  {16'd0, a0},  32'h8C31);
    chk("logic_pc", {20'd0, pc0}, 32'hA);
    chk("logic_q",  exp_q.size(), 32'd0);

    // Reset while an ST is stalled in EXEC.
    hold0();
    ld0(12'h000, i16(OP_ST,  12'h030));
    ld0(12'h002, i16(OP_HLT, 12'h000));
    ld0(12'h030, 16'hDEAD);
    rmode = 2;
    go0();
    k = 0;
    while (k < 50 && !(m0.req === 1'b1 && m0.we === 1'b1)) begin
      @(negedge clock);
      k++;
    end
    chk("st_req_seen", {31'd0, m0.we}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    #2;
    rst0 = 1'b1;
    #1;
    chk("rstx_req",  {31'd0, m0.req}, 32'd0);
    chk("rstx_we",   {31'd0, m0.we},  32'd0);
    chk("rstx_pc",   {20'd0, pc0},    32'd0);
    chk("rstx_halt", {31'd0, h0},     32'd0);
    @(negedge clock);
    chk("rstx_nowr", {16'd0, mem0[12'h030 >> 1]}, 32'hDEAD);
    exp_q.push_back({12'h030, 16'h0000});
    rmode = 0;
    go0();
    k = 0;
    while (k < 20 && !(m0.req === 1'b1 && m0.we === 1'b0 && m0.addr === 12'h000)) begin
      @(negedge clock);
      k++;
    end
    chk("rstx_refetch", {20'd0, m0.addr} | {31'd0, ~m0.req}, 32'd0);
    wait_halt0(100, k, first);
    chk("rstx_mem", {16'd0, mem0[12'h030 >> 1]}, 32'h0);
    chk("rstx_pc2", {20'd0, pc0}, 32'h4);
    chk("rstx_q",   exp_q.size(), 32'd0);

    // 32-bit core: PC wrap from 0xFFFC and ADD overflow.
    mem2[16'hFFFC >> 2] <= {OP_LD,  12'h000, 16'h0100};
    mem2[0]             <= {OP_ADD, 12'hABC, 16'h0104};
    mem2[1]             <= {OP_HLT, 28'h0};
    mem2[16'h0100 >> 2] <= 32'hFFFF_FFFF;
    mem2[16'h0104 >> 2] <= 32'h0000_0001;
    @(negedge clock);
    rst2 = 1'b0;
    wait_halt(2, 100);
    chk("w_nfetch", f2_q.size(), 32'd5);
    if (f2_q.size() >= 3) begin
      chk("w_fetch0", {16'd0, f2_q[0]}, 32'h0000FFFC);
      chk("w_fetch1", {16'd0, f2_q[2]}, 32'h0);
    end
    chk("w_a",  a2,  32'h0);
    chk("w_pc", {16'd0, pc2}, 32'h8);
    chk("w_sw", sw2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_mc.md
Name: mcu_mc

Overview:
- Parametrised multi-cycle accumulator MCU. Successor to the fixed 16-bit, zero-wait MCU0 mini core.
- Separate read and write data buses replace the shared tri-state bus.
- Memory access uses a req/ready handshake, so variable-latency memories can insert wait states.
- Adds SUB, AND, OR, JLT, JNE, HLT, signed/unsigned compare mode and halt/debug outputs. Sits between the testbench/top and the byte-addressed program/data memory model.

Parameters:
DW, 16, data/instruction width in bits; must be a multiple of 8 and at least 16
AW, 12, byte address width; must satisfy AW <= DW-4
CMP_SIGNED, 0, 1 = CMP/N flag uses two's-complement compare; 0 = unsigned
RESET_PC, 0, PC value loaded on reset (AW bits)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  AW  byte address; valid while mem_req=1
mem_wdata  out  DW  write data; valid while mem_req=1 and mem_we=1
mem_rdata  in  DW  read data; sampled on the edge where mem_req=1 and mem_ready=1
mem_ready  in  1  transfer completes on a rising edge where mem_req and mem_ready are both 1
halted  out  1  core is in HALT
dbg_pc  out  AW  current PC
dbg_a  out  DW  accumulator A
dbg_sw  out  DW  status word (N = bit DW-1, Z = bit DW-2, other bits 0)

Behaviour:
- Instruction format: OP = IR[DW-1:DW-4]; C = IR[AW-1:0], zero-extended. IR bits DW-5..AW are ignored.
- Reset (async, any state, including mid-transfer):
  - state=FETCH, PC=RESET_PC, A=0, SW=0, IR=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - An in-flight transfer is abandoned.
- All outputs are registered; memory side effects occur only on handshake edges.
- States: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On the handshake edge: IR<=mem_rdata, PC<=PC+DW/8 (wraps modulo 2^AW), go to DECODE.
  - With ready low, hold all outputs stable.
- DECODE (1 cycle, no memory access):
  - JMP(2): PC<=C.
  - JEQ(5): if Z, PC<=C.
  - JNE(8): if !Z, PC<=C.
  - JLT(7): if N, PC<=C.
  - Jumps and opcodes B-E (NOP) then go to FETCH.
  - HLT(F): go to HALT.
  - LD(0), ADD(1), ST(3), CMP(4), SUB(6), AND(9), OR(A): go to EXEC with mem_req=1, mem_addr=C, mem_we=(OP==ST), mem_wdata=A.
- EXEC: hold the request until the handshake edge, then:
  - LD: A<=rdata.
  - ADD: A<=A+rdata, modulo 2^DW.
  - SUB: A<=A-rdata, modulo 2^DW.
  - AND / OR: bitwise, result to A.
  - CMP: N<=(A<rdata), signed or unsigned per CMP_SIGNED; Z<=(A==rdata); A unchanged.
  - ST: memory written.
  - Flags change only on CMP.
  - Then go to FETCH; mem_req drops for at least the transition edge's next cycle only if the next state has no request.
- Back-to-back requests: FETCH follows EXEC directly. mem_req may stay high across transfers, but addr/we change only on handshake edges.
- Latency with mem_ready tied high:
  - Jump/NOP: 2 cycles (FETCH+DECODE).
  - Memory ops: 3 cycles.
  - Each low ready cycle adds one cycle.
- HALT: mem_req=0, halted=1; stays until reset.
- Address wrap: PC at 2^AW-DW/8 increments to 0. Misaligned C is passed through unchanged; alignment is the memory's concern.

Decomposition:
- Package mcu_pkg holds:
  - opcode localparams OP_LD..OP_HLT
  - state encoding (FETCH=0, DECODE=1, EXEC=2, HALT=3)
  - flag bit index functions N_BIT(DW)/Z_BIT(DW)
- One sub-module, mcu_alu: combinational, parametrised by DW and CMP_SIGNED. Inputs op, a, b; outputs result, n, z.
- The FSM, registers and bus interface live in mcu_mc.

Test Plan:
- Reset then run "LD 0x20; ADD 0x22; ST 0x24; HLT" with mem[0x20]=3, mem[0x22]=4, ready=1 → mem[0x24]=7 written; halted=1 after 3+3+3+2=11 cycles; dbg_pc=8.
- Same program with mem_ready asserted only every 3rd cycle → identical final memory and registers; mem_addr/mem_we stable throughout every stalled request.
- CMP with A=0xFFFF vs mem=0x0001: CMP_SIGNED=0 gives N=0, Z=0; CMP_SIGNED=1 gives N=1. A equal to mem gives Z=1. JEQ/JNE/JLT taken or not taken per flags; PC checked after DECODE.
- Countdown loop using SUB, CMP and JNE: A starts at 5, memory constant 1, loop exits when A==0; exactly 5 ST writes observed.
- Assert reset during an EXEC ST with ready held low → mem_req drops immediately (asynchronous); no write occurs; PC=RESET_PC; fetch restarts after reset release.
- DW=32, AW=16, RESET_PC=0xFFFC: first instruction fetched at 0xFFFC, second fetch at 0x0000 (wrap); ADD overflow 0xFFFFFFFF+1 gives A=0.
